// File: rtl/ray_sphere_scheduler_pkg.sv
// rtl/ray_sphere_scheduler_pkg.sv - shared types and fixed-point constants for the ray/sphere scheduler
package ray_sphere_scheduler_pkg;

    localparam int FRAC_BITS = 16;
    localparam logic signed [31:0] T_INF = 32'sh7FFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_EVAL,
        S_NEXT,
        S_RESP
    } state_t;

    typedef struct packed {
        logic [31:0] radius_sqr;
        logic [31:0] cx;
        logic [31:0] cy;
        logic [31:0] cz;
    } sphere_t;

endpackage

// File: rtl/ray_sphere_scheduler_isect_handshake.sv
// rtl/ray_sphere_scheduler_isect_handshake.sv - start stretching, finish qualification and timeout for one transaction
module ray_sphere_scheduler_isect_handshake #(
    parameter int START_W = 2,
    parameter int TIMEOUT = 63
) (
    input  logic clk,
    input  logic reset,
    input  logic go,
    input  logic waiting,
    input  logic finish,
    output logic start,
    output logic issued,
    output logic done,
    output logic timed_out
);

    localparam int SW = $clog2(START_W + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] START_LAST   = SW'(START_W - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    logic [SW-1:0] pulse_cnt;
    logic [TW-1:0] wait_cnt;
    logic          seen_low;

    // finish is still high from the previous transaction until the unit sees
    // the new start, so only a rising level after a low one counts as done
    assign start     = go;
    assign issued    = go && (pulse_cnt == START_LAST);
    assign done      = waiting && finish && seen_low;
    assign timed_out = waiting && !done && (wait_cnt == TIMEOUT_LAST);

    // pulse length counter, low-seen flag and wait-cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_cnt <= '0;
            wait_cnt  <= '0;
            seen_low  <= 1'b0;
        end else if (go) begin
            pulse_cnt <= issued ? '0 : pulse_cnt + SW'(1);
            wait_cnt  <= '0;
            seen_low  <= 1'b0;
        end else if (waiting) begin
            wait_cnt <= wait_cnt + TW'(1);
            if (!finish) begin
                seen_low <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ray_sphere_scheduler.sv
// rtl/ray_sphere_scheduler.sv - walks the sphere table for one ray and reports the nearest positive hit
module ray_sphere_scheduler
    import ray_sphere_scheduler_pkg::*;
#(
    parameter int MAX_SPHERES = 16,
    parameter int START_W     = 2,
    parameter int TIMEOUT     = 63,
    localparam int IDX_W      = $clog2(MAX_SPHERES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_orig_x,
    input  logic [31:0]      req_orig_y,
    input  logic [31:0]      req_orig_z,
    input  logic [31:0]      req_dir_x,
    input  logic [31:0]      req_dir_y,
    input  logic [31:0]      req_dir_z,
    input  logic [IDX_W:0]   req_count,
    output logic             sph_rd,
    output logic [IDX_W-1:0] sph_addr,
    input  logic [31:0]      sph_radius_sqr,
    input  logic [31:0]      sph_cx,
    input  logic [31:0]      sph_cy,
    input  logic [31:0]      sph_cz,
    output logic             isect_start,
    output logic [31:0]      isect_radius_sqr,
    output logic [31:0]      isect_center_x,
    output logic [31:0]      isect_center_y,
    output logic [31:0]      isect_center_z,
    output logic [31:0]      isect_orig_x,
    output logic [31:0]      isect_orig_y,
    output logic [31:0]      isect_orig_z,
    output logic [31:0]      isect_dir_x,
    output logic [31:0]      isect_dir_y,
    output logic [31:0]      isect_dir_z,
    input  logic             isect_finish,
    input  logic             isect_result,
    input  logic [31:0]      isect_t0,
    input  logic [31:0]      isect_t1,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_hit,
    output logic [IDX_W-1:0] resp_index,
    output logic [31:0]      resp_t,
    output logic             resp_timeout
);

    state_t             state, next_state;
    sphere_t            sph_q;
    logic [31:0]        orig_x, orig_y, orig_z, dir_x, dir_y, dir_z;
    logic [IDX_W:0]     count;
    logic [IDX_W:0]     last_idx;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   best_idx;
    logic signed [31:0] best_t;
    logic signed [31:0] cand;
    logic               cand_ok;
    logic               update;
    logic               hit;
    logic               tmo;
    logic               issued, done, timed_out;

    ray_sphere_scheduler_isect_handshake #(
        .START_W (START_W),
        .TIMEOUT (TIMEOUT)
    ) u_handshake (
        .clk       (clk),
        .reset     (reset),
        .go        (state == S_ISSUE),
        .waiting   (state == S_WAIT),
        .finish    (isect_finish),
        .start     (isect_start),
        .issued    (issued),
        .done      (done),
        .timed_out (timed_out)
    );

    assign req_ready        = (state == S_IDLE);
    assign sph_rd           = (state == S_FETCH);
    assign sph_addr         = idx;
    assign resp_valid       = (state == S_RESP);
    assign resp_hit         = hit;
    assign resp_index       = best_idx;
    assign resp_t           = best_t;
    assign resp_timeout     = tmo;
    assign isect_radius_sqr = sph_q.radius_sqr;
    assign isect_center_x   = sph_q.cx;
    assign isect_center_y   = sph_q.cy;
    assign isect_center_z   = sph_q.cz;
    assign isect_orig_x     = orig_x;
    assign isect_orig_y     = orig_y;
    assign isect_orig_z     = orig_z;
    assign isect_dir_x      = dir_x;
    assign isect_dir_y      = dir_y;
    assign isect_dir_z      = dir_z;
    assign last_idx         = count - (IDX_W + 1)'(1);

    // nearest positive distance of this sphere: entry if in front, else exit (origin inside)
    always_comb begin
        cand_ok = 1'b0;
        cand    = T_INF;
        if (isect_result) begin
            if ($signed(isect_t0) > 32'sd0) begin
                cand_ok = 1'b1;
                cand    = $signed(isect_t0);
            end else if ($signed(isect_t1) > 32'sd0) begin
                cand_ok = 1'b1;
                cand    = $signed(isect_t1);
            end
        end
        update = cand_ok && (cand < best_t);
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (req_valid) next_state = (req_count == '0) ? S_RESP : S_FETCH;
            S_FETCH: next_state = S_LOAD;
            S_LOAD:  next_state = S_ISSUE;
            S_ISSUE: if (issued) next_state = S_WAIT;
            S_WAIT: begin
                if (done) begin
                    next_state = S_EVAL;
                end else if (timed_out) begin
                    next_state = S_NEXT;
                end
            end
            S_EVAL:  next_state = S_NEXT;
            S_NEXT:  next_state = ({1'b0, idx} == last_idx) ? S_RESP : S_FETCH;
            S_RESP:  if (resp_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // ray latch, operand registers and running nearest-hit tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            orig_x   <= '0;
            orig_y   <= '0;
            orig_z   <= '0;
            dir_x    <= '0;
            dir_y    <= '0;
            dir_z    <= '0;
            count    <= '0;
            idx      <= '0;
            sph_q    <= '0;
            best_t   <= T_INF;
            best_idx <= '0;
            hit      <= 1'b0;
            tmo      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        orig_x   <= req_orig_x;
                        orig_y   <= req_orig_y;
                        orig_z   <= req_orig_z;
                        dir_x    <= req_dir_x;
                        dir_y    <= req_dir_y;
                        dir_z    <= req_dir_z;
                        count    <= req_count;
                        idx      <= '0;
                        best_t   <= T_INF;
                        best_idx <= '0;
                        hit      <= 1'b0;
                        tmo      <= 1'b0;
                    end
                end
                S_LOAD:  sph_q <= '{radius_sqr: sph_radius_sqr, cx: sph_cx, cy: sph_cy, cz: sph_cz};
                S_WAIT:  if (timed_out) tmo <= 1'b1;
                S_EVAL: begin
                    if (update) begin
                        best_t   <= cand;
                        best_idx <= idx;
                        hit      <= 1'b1;
                    end
                end
                S_NEXT:  idx <= idx + IDX_W'(1);
                default: ;
            endcase
        end
    end

endmodule
